// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = (a - b) mod 2^WIDTH, bout = (a < b).
// Latency: start accepted at edge E0, diff/bout update at edge E(WIDTH), done pulses the following cycle.
// Backpressure: none; start is ignored while busy or done, one operation per WIDTH+2 cycles.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  // Holds the WIDTH-1 result bits produced so far; the final bit joins at completion.
  logic [WIDTH-2:0] wr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] wr_full;
  logic             busy_next;
  logic             done_next;

  // Full-subtractor cell on the current LSB pair plus the registered borrow.
  always_comb begin
    d       = sa[0] ^ sb[0] ^ br;
    br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    wr_full = {d, wr};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: WIDTH shift cycles, then one DONE cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the next state so busy/done can be registered in step with the FSM.
  always_comb begin
    busy_next = (state_next == SHIFT);
    done_next = (state_next == DONE);
  end

  // Registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_next;
      done <= done_next;
    end
  end

  // Datapath: latch operands on accept, shift one bit per cycle, publish result on the last shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      wr   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            wr  <= '0;
            br  <= 1'b0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          wr  <= wr_full[WIDTH-1:1];
          br  <= br_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            diff <= wr_full;
            bout <= br_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
